// File: rtl/row_burst_ctrl_if.sv
// row_burst_ctrl_if: request, read and write handshakes plus row-array strobes
// for row_burst_ctrl. The controller connects through the slave modport and the
// requester / row array side through the master modport.
interface row_burst_ctrl_if #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int COL_ELEM_COUNT = 64,
  parameter int ROW_ADDR_WIDTH = 8
);
  localparam int COL_ADDR_WIDTH = $clog2(COL_ELEM_COUNT);
  localparam int ROW_BITS       = DATA_BIT_WIDTH * COL_ELEM_COUNT;

  // request channel
  logic                      ReqValid;
  logic                      ReqReady;
  logic                      ReqWrite;
  logic [ROW_ADDR_WIDTH-1:0] ReqRow;
  logic [COL_ADDR_WIDTH-1:0] ReqCol;
  logic [2:0]                ReqLen;
  // read data channel
  logic [DATA_BIT_WIDTH-1:0] RdData;
  logic                      RdValid;
  logic                      RdReady;
  logic                      RdLast;
  // write data channel
  logic [DATA_BIT_WIDTH-1:0] WrData;
  logic                      WrValid;
  logic                      WrReady;
  // row array side
  logic [ROW_ADDR_WIDTH-1:0] RowAddr;
  logic                      RowEnable;
  logic                      RE;
  logic                      WE;
  logic [ROW_BITS-1:0]       RowDataIn;
  logic [ROW_BITS-1:0]       RowDataOut;
  // status
  logic                      Busy;

  modport master (
    output ReqValid, ReqWrite, ReqRow, ReqCol, ReqLen, RdReady, WrData, WrValid, RowDataIn,
    input  ReqReady, RdData, RdValid, RdLast, WrReady, RowAddr, RowEnable, RE, WE,
           RowDataOut, Busy
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqRow, ReqCol, ReqLen, RdReady, WrData, WrValid, RowDataIn,
    output ReqReady, RdData, RdValid, RdLast, WrReady, RowAddr, RowEnable, RE, WE,
           RowDataOut, Busy
  );
endinterface

// File: rtl/row_burst_ctrl.sv
// row_burst_ctrl: activates a row, senses it into a local buffer, then serves a
// read or write burst of 1..8 column words (column pointer wraps inside the row).
// Write bursts finish with a single write-back cycle of the whole buffer.
// Optional feature macro ROW_BURST_OPEN_ROW_EN: keep the last sensed row open and
// serve requests to that row straight from the buffer, skipping ACTIVATE/SENSE.
module row_burst_ctrl #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int COL_ELEM_COUNT = 64,
  parameter int ROW_ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  row_burst_ctrl_if.slave bus
);
  localparam int COL_ADDR_WIDTH = $clog2(COL_ELEM_COUNT);
  localparam int ROW_BITS       = DATA_BIT_WIDTH * COL_ELEM_COUNT;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACTIVATE  = 3'd1,
    ST_SENSE     = 3'd2,
    ST_BURST_RD  = 3'd3,
    ST_BURST_WR  = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  state_t                    state_q;
  logic                      req_ready_q;
  logic                      busy_q;
  logic                      rd_valid_q;
  logic                      rd_last_q;
  logic [DATA_BIT_WIDTH-1:0] rd_data_q;
  logic                      wr_ready_q;
  logic                      row_en_q;
  logic                      re_q;
  logic                      we_q;
  logic [ROW_ADDR_WIDTH-1:0] row_addr_q;
  logic                      wr_q;
  logic [COL_ADDR_WIDTH-1:0] col_q;
  logic [3:0]                cnt_q;   // words still to transfer, 1..8

  logic [DATA_BIT_WIDTH-1:0] buf_q [COL_ELEM_COUNT];
  logic [DATA_BIT_WIDTH-1:0] row_in_s [COL_ELEM_COUNT];
  logic [ROW_BITS-1:0]       row_out_s;
  logic [3:0]                len_words_s;
  logic [COL_ADDR_WIDTH-1:0] col_d;
  logic [3:0]                cnt_d;
  logic                      wr_fire_s;
  logic                      open_hit_s;

  // Burst length decode (code 0 means 8 words) and pointer/count successors.
  always_comb begin
    len_words_s = 4'd8;
    if (bus.ReqLen != 3'd0) begin
      len_words_s = {1'b0, bus.ReqLen};
    end else begin
      len_words_s = 4'd8;
    end
    col_d     = col_q + COL_ADDR_WIDTH'(1);
    cnt_d     = cnt_q - 4'd1;
    wr_fire_s = (state_q == ST_BURST_WR) && bus.WrValid;
  end

  // Unpack the flattened sensed row and pack the buffer onto the write-back bus.
  always_comb begin
    row_out_s = '0;
    for (int c = 0; c < COL_ELEM_COUNT; c++) begin
      row_in_s[c] = bus.RowDataIn[c*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      row_out_s[c*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = buf_q[c];
    end
  end

`ifdef ROW_BURST_OPEN_ROW_EN
  logic                      open_valid_q;
  logic [ROW_ADDR_WIDTH-1:0] open_row_q;

  // Remember which row the buffer holds; a completed SENSE makes it the open row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_valid_q <= 1'b0;
      open_row_q   <= '0;
    end else if (state_q == ST_SENSE) begin
      open_valid_q <= 1'b1;
      open_row_q   <= row_addr_q;
    end else begin
      open_valid_q <= open_valid_q;
      open_row_q   <= open_row_q;
    end
  end

  assign open_hit_s = open_valid_q && (bus.ReqRow == open_row_q);
`else
  assign open_hit_s = 1'b0;
`endif

  // Row buffer: full capture at the end of SENSE, single-word updates during a write burst.
  always_ff @(posedge clk) begin
    if (state_q == ST_SENSE) begin
      for (int c = 0; c < COL_ELEM_COUNT; c++) begin
        buf_q[c] <= row_in_s[c];
      end
    end else if (wr_fire_s) begin
      buf_q[col_q] <= bus.WrData;
    end
  end

  // Burst FSM with all handshake outputs and row strobes registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      wr_ready_q  <= 1'b0;
      row_en_q    <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      row_addr_q  <= '0;
      wr_q        <= 1'b0;
      col_q       <= '0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ReqValid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            wr_q        <= bus.ReqWrite;
            row_addr_q  <= bus.ReqRow;
            col_q       <= bus.ReqCol;
            cnt_q       <= len_words_s;
            if (open_hit_s) begin
              // buffer already holds this row: go straight to the burst
              if (bus.ReqWrite) begin
                state_q    <= ST_BURST_WR;
                wr_ready_q <= 1'b1;
              end else begin
                state_q    <= ST_BURST_RD;
                rd_valid_q <= 1'b1;
                rd_data_q  <= buf_q[bus.ReqCol];
                rd_last_q  <= (len_words_s == 4'd1);
              end
            end else begin
              state_q  <= ST_ACTIVATE;
              row_en_q <= 1'b1;
              re_q     <= 1'b1;
            end
          end
        end
        ST_ACTIVATE: begin
          state_q <= ST_SENSE;
        end
        ST_SENSE: begin
          row_en_q <= 1'b0;
          re_q     <= 1'b0;
          if (wr_q) begin
            state_q    <= ST_BURST_WR;
            wr_ready_q <= 1'b1;
          end else begin
            // buffer is loaded on this same edge, so take the first word from the sense bus
            state_q    <= ST_BURST_RD;
            rd_valid_q <= 1'b1;
            rd_data_q  <= row_in_s[col_q];
            rd_last_q  <= (cnt_q == 4'd1);
          end
        end
        ST_BURST_RD: begin
          if (bus.RdReady) begin
            if (cnt_q == 4'd1) begin
              state_q     <= ST_IDLE;
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              col_q     <= col_d;
              cnt_q     <= cnt_d;
              rd_data_q <= buf_q[col_d];
              rd_last_q <= (cnt_q == 4'd2);
            end
          end
        end
        ST_BURST_WR: begin
          if (bus.WrValid) begin
            if (cnt_q == 4'd1) begin
              state_q    <= ST_WRITEBACK;
              wr_ready_q <= 1'b0;
              row_en_q   <= 1'b1;
              we_q       <= 1'b1;
            end else begin
              col_q <= col_d;
              cnt_q <= cnt_d;
            end
          end
        end
        ST_WRITEBACK: begin
          state_q     <= ST_IDLE;
          row_en_q    <= 1'b0;
          we_q        <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
          wr_ready_q  <= 1'b0;
          row_en_q    <= 1'b0;
          re_q        <= 1'b0;
          we_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ReqReady   = req_ready_q;
  assign bus.Busy       = busy_q;
  assign bus.RdValid    = rd_valid_q;
  assign bus.RdLast     = rd_last_q;
  assign bus.RdData     = rd_data_q;
  assign bus.WrReady    = wr_ready_q;
  assign bus.RowEnable  = row_en_q;
  assign bus.RE         = re_q;
  assign bus.WE         = we_q;
  assign bus.RowAddr    = row_addr_q;
  assign bus.RowDataOut = row_out_s;
endmodule

// File: tb/tb_row_burst_ctrl.sv
// tb_row_burst_ctrl: directed and randomized bursts against a row-array memory
// model plus an expected-contents model of every row.
module tb_row_burst_ctrl;
  localparam int DW = 32;
  localparam int CN = 64;
  localparam int RW = 8;
  localparam int NR = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  row_burst_ctrl_if #(.DATA_BIT_WIDTH(DW), .COL_ELEM_COUNT(CN), .ROW_ADDR_WIDTH(RW)) bus ();

  row_burst_ctrl #(.DATA_BIT_WIDTH(DW), .COL_ELEM_COUNT(CN), .ROW_ADDR_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // row array attached to the DUT, and the contents every row is expected to hold
  logic [DW-1:0] mem     [NR][CN];
  logic [DW-1:0] exp_mem [NR][CN];

  int n_cmp = 0;
  int n_err = 0;

  // strobe monitor state
  int              act_count = 0;
  int              we_count  = 0;
  int              viol      = 0;
  logic [RW-1:0]   act_addr  = '0;
  logic [RW-1:0]   we_addr   = '0;
  logic [DW*CN-1:0] we_data  = '0;
  logic            re_prev   = 1'b0;

`ifdef ROW_BURST_OPEN_ROW_EN
  logic          m_open_valid = 1'b0;
  logic [RW-1:0] m_open_row   = '0;
`endif

  // the row array presents the addressed row on the sense bus
  always_comb begin
    bus.RowDataIn = '0;
    for (int c = 0; c < CN; c++) begin
      bus.RowDataIn[c*DW +: DW] = mem[bus.RowAddr][c];
    end
  end

  // the row array stores the write-back bus on every WE cycle
  always @(posedge clk) begin
    if (bus.WE) begin
      for (int c = 0; c < CN; c++) begin
        mem[bus.RowAddr][c] <= bus.RowDataOut[c*DW +: DW];
      end
    end
  end

  // strobe monitor sampled mid-cycle
  always @(negedge clk) begin
    if (bus.RE && bus.WE) viol++;
    if (!bus.RowEnable && (bus.RE || bus.WE)) viol++;
    if (bus.RE && !re_prev) begin
      act_count++;
      act_addr = bus.RowAddr;
    end
    re_prev = bus.RE;
    if (bus.WE) begin
      we_count++;
      we_addr = bus.RowAddr;
      we_data = bus.RowDataOut;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_latency(input logic [RW-1:0] row);
`ifdef ROW_BURST_OPEN_ROW_EN
    return (m_open_valid && row == m_open_row) ? 3'd1 : 3'd3;
`else
    return (row === row) ? 3 : 3;
`endif
  endfunction

  task automatic note_open(input logic [RW-1:0] row);
`ifdef ROW_BURST_OPEN_ROW_EN
    m_open_valid = 1'b1;
    m_open_row   = row;
`else
    if (row === 'x) $display("note: unknown row");
`endif
  endtask

  task automatic note_reset();
`ifdef ROW_BURST_OPEN_ROW_EN
    m_open_valid = 1'b0;
`endif
  endtask

  function automatic int row_mis(input logic [RW-1:0] row);
    int m = 0;
    for (int c = 0; c < CN; c++) begin
      if (we_data[c*DW +: DW] !== exp_mem[row][c]) m++;
    end
    return m;
  endfunction

  // offer a request and return just after the accepting clock edge
  task automatic issue(input logic w, input logic [RW-1:0] row, input logic [5:0] col,
                       input logic [2:0] len);
    int g = 0;
    @(negedge clk);
    bus.ReqValid = 1'b1;
    bus.ReqWrite = w;
    bus.ReqRow   = row;
    bus.ReqCol   = col;
    bus.ReqLen   = len;
    while (!bus.ReqReady && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready", {63'd0, bus.ReqReady}, 64'd1);
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    bus.ReqRow   = 8'($urandom);
  endtask

  task automatic do_read(input string tag, input logic [RW-1:0] row, input logic [5:0] col,
                         input logic [2:0] len, input logic [15:0] pat);
    int n     = (len == 3'd0) ? 8 : int'(len);
    int lat   = exp_latency(row);
    int acts0 = act_count;
    int k = 0, words = 0, step = 0;
    bit seen = 1'b0;
    issue(1'b0, row, col, len);
    while (words < n && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.RdValid) begin
        if (!seen) begin
          seen = 1'b1;
          chk({tag, "_latency"}, 64'(k), 64'(lat));
        end
        bus.RdReady = pat[step % 16];
        step++;
        chk({tag, "_rddata"}, 64'(bus.RdData), 64'(exp_mem[row][(int'(col) + words) % CN]));
        chk({tag, "_rdlast"}, {63'd0, bus.RdLast}, {63'd0, (words == n - 1)});
        if (bus.RdReady) words++;
      end else begin
        bus.RdReady = 1'($urandom);
      end
    end
    chk({tag, "_words"}, 64'(words), 64'(n));
    @(negedge clk);
    #1;
    bus.RdReady = 1'b0;
    chk({tag, "_rdvalid_end"}, {63'd0, bus.RdValid}, 64'd0);
    chk({tag, "_idle_end"}, {62'd0, bus.ReqReady, bus.Busy}, 64'd2);
    chk({tag, "_activates"}, 64'(act_count - acts0), (lat == 3) ? 64'd1 : 64'd0);
    if (lat == 3) chk({tag, "_act_row"}, 64'(act_addr), 64'(row));
    note_open(row);
  endtask

  task automatic do_write(input string tag, input logic [RW-1:0] row, input logic [5:0] col,
                          input logic [2:0] len, input logic [255:0] dvec,
                          input logic [15:0] pat);
    int n     = (len == 3'd0) ? 8 : int'(len);
    int lat   = exp_latency(row);
    int acts0 = act_count;
    int we0   = we_count;
    int k = 0, words = 0, step = 0;
    bit seen = 1'b0;
    issue(1'b1, row, col, len);
    while (words < n && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.WrReady) begin
        if (!seen) begin
          seen = 1'b1;
          chk({tag, "_latency"}, 64'(k), 64'(lat));
        end
        if (pat[step % 16]) begin
          bus.WrValid = 1'b1;
          bus.WrData  = dvec[words*DW +: DW];
          words++;
        end else begin
          bus.WrValid = 1'b0;
          bus.WrData  = $urandom;
        end
        step++;
      end else begin
        bus.WrValid = 1'($urandom);
        bus.WrData  = $urandom;
      end
    end
    chk({tag, "_words"}, 64'(words), 64'(n));
    for (int i = 0; i < n; i++) begin
      exp_mem[row][(int'(col) + i) % CN] = dvec[i*DW +: DW];
    end
    @(negedge clk);
    bus.WrValid = 1'b1;     // outside the burst: must be ignored
    bus.WrData  = $urandom;
    @(negedge clk);
    bus.WrValid = 1'b0;
    #1;
    chk({tag, "_we_pulses"}, 64'(we_count - we0), 64'd1);
    chk({tag, "_we_row"}, 64'(we_addr), 64'(row));
    chk({tag, "_wb_cols_wrong"}, 64'(row_mis(row)), 64'd0);
    chk({tag, "_idle_end"}, {62'd0, bus.ReqReady, bus.Busy}, 64'd2);
    chk({tag, "_activates"}, 64'(act_count - acts0), (lat == 3) ? 64'd1 : 64'd0);
    note_open(row);
  endtask

  initial begin
    logic [RW-1:0] r_row;
    logic [255:0]  dvec;
    int            we0;
    int            g;

    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqRow   = '0;
    bus.ReqCol   = '0;
    bus.ReqLen   = '0;
    bus.RdReady  = 1'b0;
    bus.WrData   = '0;
    bus.WrValid  = 1'b0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < CN; c++) begin
        logic [DW-1:0] v;
        v = (r == 5) ? DW'(32'h1000 + c) : DW'($urandom);
        mem[r][c]     <= v;
        exp_mem[r][c] = v;
      end
    end

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_reqready", {63'd0, bus.ReqReady}, 64'd1);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_rd", {bus.RdValid, bus.RdLast, 30'd0, bus.RdData}, 64'd0);
    chk("rst_strobes", {60'd0, bus.WrReady, bus.RowEnable, bus.RE, bus.WE}, 64'd0);
    chk("rst_rowaddr", 64'(bus.RowAddr), 64'd0);
    rst_n = 1'b1;

    // directed bursts
    do_read("rd_row5_col0", 8'd5, 6'd0, 3'd4, 16'hFFFF);
    do_read("rd_wrap62", 8'd5, 6'd62, 3'd4, 16'hFFFF);
    do_write("wr_row3_gap", 8'd3, 6'd10, 3'd2, {192'd0, 32'hAAAA0002, 32'hAAAA0001}, 16'hFFFD);
    do_read("rd_row3_back", 8'd3, 6'd9, 3'd4, 16'hFFFF);
    do_read("rd_len8_toggle", 8'd9, 6'd60, 3'd0, 16'h5555);
    do_read("rd_row7_a", 8'd7, 6'd4, 3'd3, 16'hFFFF);
    do_read("rd_row7_b", 8'd7, 6'd5, 3'd1, 16'hFFFF);
    do_read("rd_row8", 8'd8, 6'd63, 3'd2, 16'hFFFF);

    // reset during the second word of a write burst
    we0 = we_count;
    issue(1'b1, 8'd3, 6'd20, 3'd4);
    g = 0;
    while (!bus.WrReady && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rstwr_wrready", {63'd0, bus.WrReady}, 64'd1);
    bus.WrValid = 1'b1;
    bus.WrData  = 32'hDEAD0001;
    @(negedge clk);
    bus.WrData  = 32'hDEAD0002;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwr_strobes", {60'd0, bus.WrReady, bus.RowEnable, bus.RE, bus.WE}, 64'd0);
    chk("rstwr_idle", {62'd0, bus.ReqReady, bus.Busy}, 64'd2);
    bus.WrValid = 1'b0;
    note_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rstwr_no_we", 64'(we_count - we0), 64'd0);
    do_read("rd_after_rst", 8'd3, 6'd20, 3'd4, 16'hFFFF);

    // randomized bursts
    for (int i = 0; i < 16; i++) begin
      r_row = RW'((($urandom % 4) * 2) + 3);
      for (int j = 0; j < 8; j++) dvec[j*DW +: DW] = $urandom;
      if ($urandom % 2 == 0) begin
        do_write("rand_wr", r_row, 6'($urandom), 3'($urandom), dvec, 16'($urandom) | 16'd1);
      end else begin
        do_read("rand_rd", r_row, 6'($urandom), 3'($urandom), 16'($urandom) | 16'd1);
      end
    end

    chk("strobe_rule_violations", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
